rv_imm_gen_pl: RTL and testbench
================================

RV_IMM_GEN_PL -- requirements
Module: rv_imm_gen_pl

Interface
REQ-001 SHALL take parameter XLEN, default 64, as the immediate output width; legal values are 32 and 64.
REQ-002 SHALL take parameter TAG_W, default 8, as the width of the sideband tag passed through unchanged.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid_i, input, 1 bit: an instruction is offered.
REQ-006 SHALL have port in_ready_o, output, 1 bit: the block accepts the offered instruction this cycle.
REQ-007 SHALL have port instr_i, input, 32 bits: the RV instruction word.
REQ-008 SHALL have port tag_i, input, TAG_W bits: the sideband tag.
REQ-009 SHALL have port out_valid_o, output, 1 bit: a result is presented.
REQ-010 SHALL have port out_ready_i, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port imm_o, output, XLEN bits: the sign-extended immediate.
REQ-012 SHALL have port fmt_o, output, 3 bits: format code I=0, S=1, B=2, U=3, J=4, NONE=7.
REQ-013 SHALL have port illegal_o, output, 1 bit: the opcode has no immediate format.
REQ-014 SHALL have port tag_o, output, TAG_W bits: the tag of the presented result.

Function
REQ-015 SHALL decode the format from instr_i[6:0].
- I: 0000011, 0010011, 0011011, 1100111, 0000111, 1110011.
- S: 0100011, 0100111.
- B: 1100011.
- U: 0110111, 0010111.
- J: 1101111.
- Any other opcode: NONE.
REQ-016 SHALL build the immediate per format, each value sign-extended from instr[31] to XLEN.
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-017 SHALL, for format NONE, output imm_o = 0 and illegal_o = 1; for every other format, illegal_o = 0.
REQ-018 SHALL register results through a 2-entry skid buffer; fill levels are EMPTY, ONE and FULL.
REQ-019 SHALL give a latency of exactly 1 cycle from an accept (in_valid_i & in_ready_o) to out_valid_o when the buffer was EMPTY.
REQ-020 SHALL drive in_ready_o from a register; it is 1 in EMPTY and ONE, and 0 in FULL.
REQ-021 SHALL hold out_valid_o, imm_o, fmt_o, illegal_o and tag_o stable while out_valid_o & !out_ready_i.
REQ-022 SHALL deliver results in acceptance order, with no loss or duplication.
REQ-023 SHALL apply these level transitions, where "acc" is an accept and "pop" is out_valid_o & out_ready_i:
- EMPTY to ONE on acc.
- ONE to FULL on acc without pop.
- ONE to EMPTY on pop without acc.
- ONE stays ONE on acc with pop.
- FULL to ONE on pop.
REQ-024 SHALL, on a simultaneous acc and pop in ONE, present the new entry on the next cycle.
REQ-025 SHALL, on a pop in FULL, move the skid entry to the output stage on the next cycle.
REQ-026 SHALL keep out_valid_o = 1 if and only if the level is not EMPTY.

Reset
REQ-027 SHALL, when rst_i is sampled high, force the level to EMPTY on that edge, discarding any in-flight or held entries, including in the middle of a stall.
REQ-028 SHALL hold these values from reset: out_valid_o = 0, in_ready_o = 1, imm_o = 0, fmt_o = 7, illegal_o = 0, tag_o = 0.
REQ-029 SHALL ignore in_valid_i in any cycle in which rst_i is high.

Structure
REQ-030 SHALL place the opcode localparams and the 3-bit format codes in the shared package rv_pkg.
REQ-031 SHALL implement the combinational format decode and immediate build as sub-module rv_imm_dec, parametrised by XLEN.
REQ-032 SHALL keep the skid-buffer control (level register, two data slots) in rv_imm_gen_pl.

Verification
REQ-033 SHALL cover, with XLEN=64: instr 0xFFF00093 (addi -1) -> imm_o = 0xFFFFFFFFFFFFFFFF, fmt_o = 0, illegal_o = 0, valid 1 cycle after accept.
REQ-034 SHALL cover the format set:
- 0x00B53423 (sd 8) -> imm 8, fmt 1.
- 0xFE000EE3 (beq -4) -> imm 0xFFFFFFFFFFFFFFFC, fmt 2.
- 0x123450B7 (lui) -> imm 0x0000000012345000, fmt 3.
- 0x0010006F (jal 0x800) -> imm 0x800, fmt 4.
REQ-035 SHALL cover instr 0x00000033 (R-type) -> imm_o = 0, fmt_o = 7, illegal_o = 1.
REQ-036 SHALL cover backpressure: out_ready_i = 0 for 3 cycles while sending tags 1, 2, 3.
- in_ready_o drops after 2 accepts.
- Outputs stay at tag 1.
- After out_ready_i = 1, the order is 1, 2, 3 with no gaps or duplicates.
REQ-037 SHALL cover streaming: in_valid_i = out_ready_i = 1 for 10 cycles -> one result per cycle, in_ready_o constantly 1.
REQ-038 SHALL cover reset while FULL: next cycle out_valid_o = 0 and in_ready_o = 1; with XLEN=32, 0xFFF00093 -> imm_o = 0xFFFFFFFF.

Source files
------------

// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared RISC-V definitions used by the immediate generator:
//   - 7-bit major opcode constants for every opcode that carries an immediate
//   - 3-bit immediate format codes (I, S, B, U, J, NONE)
//   - fill-level encoding of the 2-entry output skid buffer
//   - decode_fmt(): maps a major opcode to its immediate format
// ---------------------------------------------------------------------------
package rv_pkg;

  // Major opcodes (instr[6:0]) that carry an immediate
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LOAD_FP   = 7'b0000111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP  = 7'b0100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  // Immediate format codes as they appear on fmt_o
  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_S    = 3'd1;
  localparam logic [2:0] FMT_B    = 3'd2;
  localparam logic [2:0] FMT_U    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_NONE = 3'd7;

  // Fill level of the output skid buffer
  typedef enum logic [1:0] {
    LVL_EMPTY = 2'd0,
    LVL_ONE   = 2'd1,
    LVL_FULL  = 2'd2
  } skid_lvl_e;

  // Opcode-to-format lookup; anything not listed has no immediate
  function automatic logic [2:0] decode_fmt(input logic [6:0] opcode);
    logic [2:0] fmt;
    fmt = FMT_NONE;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32,
      OPC_JALR, OPC_LOAD_FP, OPC_SYSTEM:  fmt = FMT_I;
      OPC_STORE, OPC_STORE_FP:            fmt = FMT_S;
      OPC_BRANCH:                         fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                 fmt = FMT_U;
      OPC_JAL:                            fmt = FMT_J;
      default:                            fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/rv_imm_dec.sv
// ---------------------------------------------------------------------------
// rv_imm_dec
// Purely combinational immediate decoder. Classifies the instruction by its
// major opcode and assembles the sign-extended immediate for that format.
//
// Parameters:
//   XLEN    - width of the produced immediate (32 or 64)
// Ports:
//   instr   - in,  32 bits : RISC-V instruction word
//   imm     - out, XLEN    : sign-extended immediate (0 when no format)
//   fmt     - out, 3 bits  : format code, FMT_NONE for opcodes without one
//   illegal - out, 1 bit   : opcode has no immediate format
// ---------------------------------------------------------------------------
module rv_imm_dec
  import rv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [2:0]  fmt_d;
  logic [31:0] imm32;

  // Every RV immediate has its sign in instr[31], so the value is first built
  // as a 32-bit signed quantity and then widened by a signed size cast. This
  // keeps the same code legal for XLEN=32, where the cast is a no-op.
  always_comb begin
    fmt_d = decode_fmt(instr[6:0]);
    imm32 = 32'd0;
    case (fmt_d)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                      instr[20], instr[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  assign imm     = XLEN'($signed(imm32));
  assign fmt     = fmt_d;
  assign illegal = (fmt_d == FMT_NONE);

endmodule

// File: rtl/rv_imm_gen_pl.sv
// ---------------------------------------------------------------------------
// rv_imm_gen_pl
// Pipelined immediate generator. Instructions arrive on a valid/ready input
// port, are decoded by rv_imm_dec and the result is registered through a
// 2-entry skid buffer onto a valid/ready output port. The sideband tag
// travels unchanged with each instruction.
//
// Parameters:
//   XLEN  - immediate width (32 or 64)
//   TAG_W - sideband tag width
// Ports:
//   clk_i       - in  : clock
//   rst_i       - in  : synchronous active-high reset
//   in_valid_i  - in  : instruction offered
//   in_ready_o  - out : instruction accepted this cycle (registered)
//   instr_i     - in  : 32-bit instruction word
//   tag_i       - in  : sideband tag
//   out_valid_o - out : result presented
//   out_ready_i - in  : consumer accepts result
//   imm_o       - out : sign-extended immediate
//   fmt_o       - out : format code (I=0,S=1,B=2,U=3,J=4,NONE=7)
//   illegal_o   - out : opcode has no immediate format
//   tag_o       - out : tag of the presented result
// ---------------------------------------------------------------------------
module rv_imm_gen_pl
  import rv_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);

  // Decoded view of the instruction currently on the input port
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  rv_imm_dec #(
    .XLEN (XLEN)
  ) u_dec (
    .instr   (instr_i),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  skid_lvl_e       level_q;
  logic            in_ready_q;
  logic            out_valid_q;

  // Output stage: the entry currently presented to the consumer
  logic [XLEN-1:0]  out_imm_q;
  logic [2:0]       out_fmt_q;
  logic             out_ill_q;
  logic [TAG_W-1:0] out_tag_q;

  // Skid stage: the second entry, only occupied when the level is FULL
  logic [XLEN-1:0]  skid_imm_q;
  logic [2:0]       skid_fmt_q;
  logic             skid_ill_q;
  logic [TAG_W-1:0] skid_tag_q;

  logic acc;
  logic pop;

  assign acc = in_valid_i & in_ready_q;
  assign pop = out_valid_q & out_ready_i;

  // Skid-buffer control. in_ready and out_valid are registered copies of
  // "level != FULL" and "level != EMPTY", so they are updated alongside the
  // level in every branch. Reset has priority, which both discards any held
  // entries and makes in_valid_i irrelevant during the reset cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q     <= LVL_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_fmt_q   <= FMT_NONE;
      out_ill_q   <= 1'b0;
      out_tag_q   <= '0;
      skid_imm_q  <= '0;
      skid_fmt_q  <= FMT_NONE;
      skid_ill_q  <= 1'b0;
      skid_tag_q  <= '0;
    end else begin
      case (level_q)
        LVL_EMPTY: begin
          if (acc) begin
            level_q     <= LVL_ONE;
            out_valid_q <= 1'b1;
            out_imm_q   <= dec_imm;
            out_fmt_q   <= dec_fmt;
            out_ill_q   <= dec_ill;
            out_tag_q   <= tag_i;
          end
        end

        LVL_ONE: begin
          if (acc && pop) begin
            // Presented entry leaves while the new one takes its place
            out_imm_q <= dec_imm;
            out_fmt_q <= dec_fmt;
            out_ill_q <= dec_ill;
            out_tag_q <= tag_i;
          end else if (acc) begin
            // Consumer stalled: park the new entry behind the presented one
            level_q    <= LVL_FULL;
            in_ready_q <= 1'b0;
            skid_imm_q <= dec_imm;
            skid_fmt_q <= dec_fmt;
            skid_ill_q <= dec_ill;
            skid_tag_q <= tag_i;
          end else if (pop) begin
            level_q     <= LVL_EMPTY;
            out_valid_q <= 1'b0;
          end
        end

        LVL_FULL: begin
          // No accept is possible here since in_ready is low
          if (pop) begin
            level_q    <= LVL_ONE;
            in_ready_q <= 1'b1;
            out_imm_q  <= skid_imm_q;
            out_fmt_q  <= skid_fmt_q;
            out_ill_q  <= skid_ill_q;
            out_tag_q  <= skid_tag_q;
          end
        end

        default: begin
          level_q     <= LVL_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign imm_o       = out_imm_q;
  assign fmt_o       = out_fmt_q;
  assign illegal_o   = out_ill_q;
  assign tag_o       = out_tag_q;

endmodule

// File: tb/tb_rv_imm_gen_pl.sv
// ---------------------------------------------------------------------------
// tb_rv_imm_gen_pl
// Self-checking bench for rv_imm_gen_pl. A 64-bit instance is the main DUT;
// a 32-bit instance shares its inputs to check narrow sign extension.
// Accepted instructions push a reference result into a queue; every output
// handshake pops and compares it.
// ---------------------------------------------------------------------------
module tb_rv_imm_gen_pl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [7:0]  tag_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] imm_o;
  logic [2:0]  fmt_o;
  logic        illegal_o;
  logic [7:0]  tag_o;

  logic        in_ready32;
  logic        out_valid32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic        illegal32;
  logic [7:0]  tag32;

  always #5 clk_i = ~clk_i;

  rv_imm_gen_pl #(.XLEN(64), .TAG_W(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .imm_o       (imm_o),
    .fmt_o       (fmt_o),
    .illegal_o   (illegal_o),
    .tag_o       (tag_o)
  );

  rv_imm_gen_pl #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready32),
    .instr_i     (instr_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid32),
    .out_ready_i (out_ready_i),
    .imm_o       (imm32),
    .fmt_o       (fmt32),
    .illegal_o   (illegal32),
    .tag_o       (tag32)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   n_vectors = 0;
  int   n_miscompares = 0;
  int   pop_cnt = 0;
  logic last_acc;

  // Reference decoder written directly from the instruction-set encodings
  function automatic exp_t model(input logic [31:0] ins, input logic [7:0] tag);
    exp_t e;
    e.tag = tag;
    e.ill = 1'b0;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b0000111, 7'b1110011: begin
        e.fmt = 3'd0;
        e.imm = {{52{ins[31]}}, ins[31:20]};
      end
      7'b0100011, 7'b0100111: begin
        e.fmt = 3'd1;
        e.imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        e.fmt = 3'd2;
        e.imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = 3'd3;
        e.imm = {{32{ins[31]}}, ins[31:12], 12'b0};
      end
      7'b1101111: begin
        e.fmt = 3'd4;
        e.imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: begin
        e.fmt = 3'd7;
        e.imm = 64'd0;
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One clock cycle with the inputs as currently driven. Handshakes are
  // evaluated at posedge+1, where registered outputs and inputs are stable.
  task automatic tick();
    exp_t e;
    logic in_rst;
    in_rst   = rst_i;
    last_acc = 1'b0;
    if (!in_rst && out_valid_o && out_ready_i) begin
      pop_cnt++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_pop", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("imm", imm_o, e.imm);
        checkOutput("fmt", {61'd0, fmt_o}, {61'd0, e.fmt});
        checkOutput("illegal", {63'd0, illegal_o}, {63'd0, e.ill});
        checkOutput("tag", {56'd0, tag_o}, {56'd0, e.tag});
      end
    end
    if (!in_rst && in_valid_i && in_ready_o) begin
      sb.push_back(model(instr_i, tag_i));
      last_acc = 1'b1;
    end
    @(posedge clk_i);
    #1;
    if (in_rst) sb.delete();
  endtask

  // Offer one instruction and hold it until accepted (bounded)
  task automatic applyStimulus(input logic [31:0] ins, input logic [7:0] tag);
    bit done;
    done       = 1'b0;
    instr_i    = ins;
    tag_i      = tag;
    in_valid_i = 1'b1;
    for (int i = 0; i < 16 && !done; i++) begin
      tick();
      done = last_acc;
    end
    if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 32 && sb.size() > 0; i++) tick();
    checkOutput("drain_left", 64'(sb.size()), 64'd0);
    checkOutput("drain_valid", {63'd0, out_valid_o}, 64'd0);
  endtask

  localparam int NVEC = 6;
  logic [31:0] vec_instr [NVEC] = '{32'hFFF00093, 32'h00B53423, 32'hFE000EE3,
                                    32'h123450B7, 32'h0010006F, 32'h00000033};
  logic [6:0]  opc_pool  [14]   = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h07, 7'h73, 7'h23,
                                    7'h27, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b1;
    instr_i     = 32'hFFF00093;
    tag_i       = 8'hAA;
    out_ready_i = 1'b1;
    tick();
    tick();
    rst_i      = 1'b0;
    in_valid_i = 1'b0;

    // Reset state
    checkOutput("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
    checkOutput("rst_imm", imm_o, 64'd0);
    checkOutput("rst_fmt", {61'd0, fmt_o}, 64'd7);
    checkOutput("rst_illegal", {63'd0, illegal_o}, 64'd0);
    checkOutput("rst_tag", {56'd0, tag_o}, 64'd0);

    // addi -1: valid one cycle after accept, with explicit expected values
    applyStimulus(32'hFFF00093, 8'd10);
    checkOutput("lat1_valid", {63'd0, out_valid_o}, 64'd1);
    checkOutput("addi_imm", imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("addi_fmt", {61'd0, fmt_o}, 64'd0);
    drain();

    // Format set, each followed by explicit constants
    applyStimulus(32'h00B53423, 8'd11);
    checkOutput("sd_imm", imm_o, 64'd8);
    checkOutput("sd_fmt", {61'd0, fmt_o}, 64'd1);
    drain();
    applyStimulus(32'hFE000EE3, 8'd12);
    checkOutput("beq_imm", imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("beq_fmt", {61'd0, fmt_o}, 64'd2);
    drain();
    applyStimulus(32'h123450B7, 8'd13);
    checkOutput("lui_imm", imm_o, 64'h0000_0000_1234_5000);
    checkOutput("lui_fmt", {61'd0, fmt_o}, 64'd3);
    drain();
    applyStimulus(32'h0010006F, 8'd14);
    checkOutput("jal_imm", imm_o, 64'h800);
    checkOutput("jal_fmt", {61'd0, fmt_o}, 64'd4);
    drain();
    applyStimulus(32'h00000033, 8'd15);
    checkOutput("rtype_imm", imm_o, 64'd0);
    checkOutput("rtype_fmt", {61'd0, fmt_o}, 64'd7);
    checkOutput("rtype_ill", {63'd0, illegal_o}, 64'd1);
    drain();

    // Backpressure: tags 1,2,3 with the consumer stalled
    out_ready_i = 1'b0;
    applyStimulus(32'h00100093, 8'd1);
    checkOutput("bp_rdy_one", {63'd0, in_ready_o}, 64'd1);
    applyStimulus(32'h00200093, 8'd2);
    checkOutput("bp_rdy_full", {63'd0, in_ready_o}, 64'd0);
    checkOutput("bp_hold_tag", {56'd0, tag_o}, 64'd1);
    instr_i    = 32'h00300093;
    tag_i      = 8'd3;
    in_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("bp_no_acc", {63'd0, last_acc}, 64'd0);
      checkOutput("bp_stall_tag", {56'd0, tag_o}, 64'd1);
      checkOutput("bp_stall_imm", imm_o, 64'd1);
      checkOutput("bp_stall_valid", {63'd0, out_valid_o}, 64'd1);
    end
    out_ready_i = 1'b1;
    applyStimulus(32'h00300093, 8'd3);
    drain();

    // Streaming: one result per cycle with in_ready constantly high
    pop_cnt     = 0;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instr_i = {$urandom()} & 32'hFFFF_FF80;
      instr_i[6:0] = opc_pool[$urandom_range(0, 13)];
      tag_i   = 8'(32 + i);
      checkOutput("stream_rdy", {63'd0, in_ready_o}, 64'd1);
      tick();
      checkOutput("stream_acc", {63'd0, last_acc}, 64'd1);
      checkOutput("stream_valid", {63'd0, out_valid_o}, 64'd1);
    end
    in_valid_i = 1'b0;
    checkOutput("stream_pops", 64'(pop_cnt), 64'd9);
    drain();

    // Table vectors through the scoreboard with random backpressure
    for (int i = 0; i < 40; i++) begin
      in_valid_i  = 1'($urandom_range(0, 1));
      out_ready_i = 1'($urandom_range(0, 1));
      if (i < NVEC) instr_i = vec_instr[i];
      else begin
        instr_i = $urandom();
        instr_i[6:0] = opc_pool[$urandom_range(0, 13)];
      end
      tag_i = 8'(64 + i);
      tick();
    end
    drain();

    // Reset while FULL, with in_valid high during the reset cycle
    out_ready_i = 1'b0;
    applyStimulus(32'h00100093, 8'd1);
    applyStimulus(32'h00200093, 8'd2);
    checkOutput("full_rdy", {63'd0, in_ready_o}, 64'd0);
    rst_i      = 1'b1;
    in_valid_i = 1'b1;
    instr_i    = 32'hFFF00093;
    tag_i      = 8'h55;
    tick();
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    checkOutput("rstf_valid", {63'd0, out_valid_o}, 64'd0);
    checkOutput("rstf_rdy", {63'd0, in_ready_o}, 64'd1);
    checkOutput("rstf_tag", {56'd0, tag_o}, 64'd0);
    checkOutput("rstf_fmt", {61'd0, fmt_o}, 64'd7);
    tick();
    checkOutput("rstf_ignored", {63'd0, out_valid_o}, 64'd0);

    // Narrow instance sign-extends to 32 bits
    out_ready_i = 1'b1;
    applyStimulus(32'hFFF00093, 8'd7);
    checkOutput("x32_valid", {63'd0, out_valid32}, 64'd1);
    checkOutput("x32_imm", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFF);
    checkOutput("x32_fmt", {61'd0, fmt32}, 64'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
